// File: rtl/inv_pulse_meter.sv
// inv_pulse_meter
//   Measurement stage for the inverter cell output. Synchronises sig_in into the clk1
//   domain and detects its edges. It then measures one full high phase and the low phase
//   that follows, in clk1 cycles, and presents the counts on a valid/ready handshake.
//
// Ports
//   clk1        in   single clock, all logic on the rising edge
//   rstn1       in   synchronous reset, active-low
//   sig_in      in   inverter output under test, asynchronous to clk1
//   meas_en     in   1 = measure, 0 = abort and hold in idle
//   meas_ready  in   consumer accepts the result
//   meas_valid  out  result available (registered)
//   high_cnt    out  clk1 cycles the signal was high
//   low_cnt     out  clk1 cycles the signal was low
//   period_cnt  out  high_cnt + low_cnt, one bit wider so it never wraps
//   ovf         out  a phase counter saturated during this measurement
module inv_pulse_meter #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk1,
  input  logic             rstn1,
  input  logic             sig_in,
  input  logic             meas_en,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             ovf
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitRise,
    StMeasHigh,
    StMeasLow,
    StReport
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    s_prev_q;
  logic [CNT_W-1:0]        high_q, high_d;
  logic [CNT_W-1:0]        low_q, low_d;
  logic                    ovf_q, ovf_d;
  logic                    valid_q, valid_d;

  logic s;
  logic rise;
  logic fall;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev_q;
  assign fall = ~s & s_prev_q;

  always_ff @(posedge clk1) begin
    if (!rstn1) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
      state_q  <= StIdle;
      high_q   <= '0;
      low_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_prev_q <= s;
      state_q  <= state_d;
      high_q   <= high_d;
      low_q    <= low_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    // Dropping meas_en aborts from any active state and wins over edges and handshake.
    if (state_q != StIdle && !meas_en) begin
      state_d = StIdle;
      high_d  = '0;
      low_d   = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          high_d  = '0;
          low_d   = '0;
          ovf_d   = 1'b0;
          valid_d = 1'b0;
          if (meas_en) state_d = StWaitRise;
        end
        StWaitRise: begin
          if (rise) begin
            state_d = StMeasHigh;
            high_d  = {{(CNT_W-1){1'b0}}, 1'b1};
            low_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        StMeasHigh: begin
          if (fall) begin
            state_d = StMeasLow;
            low_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (s) begin
            // Saturate rather than wrap; the measurement still runs to its end.
            if (high_q == CntMax) ovf_d = 1'b1;
            else                  high_d = high_q + 1'b1;
          end
        end
        StMeasLow: begin
          if (rise) begin
            // The closing rise ends this result and is not reused as the next start.
            state_d = StReport;
            valid_d = 1'b1;
          end else if (!s) begin
            if (low_q == CntMax) ovf_d = 1'b1;
            else                 low_d = low_q + 1'b1;
          end
        end
        StReport: begin
          if (meas_ready) begin
            state_d = StWaitRise;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign meas_valid = valid_q;
  assign high_cnt   = high_q;
  assign low_cnt    = low_q;
  assign ovf        = ovf_q;
  assign period_cnt = {1'b0, high_q} + {1'b0, low_q};

endmodule

// File: tb/tb_inv_pulse_meter.sv
// tb_inv_pulse_meter
//   Directed bench for inv_pulse_meter. One instance uses the default 8-bit counters and
//   a second uses 4-bit counters to reach saturation. Both share sig_in; each has its
//   own enable. A monitor records every result on the first cycle its valid is high.
module tb_inv_pulse_meter;

  typedef struct {
    int unsigned h;
    int unsigned l;
    int unsigned p;
    int unsigned o;
  } res_t;

  logic       clk1 = 1'b0;
  logic       rstn1;
  logic       sig_in;
  logic       meas_en, meas_en4;
  logic       meas_ready;
  logic       meas_valid, meas_valid4;
  logic [7:0] high_cnt, low_cnt;
  logic [8:0] period_cnt;
  logic       ovf;
  logic [3:0] high_cnt4, low_cnt4;
  logic [4:0] period_cnt4;
  logic       ovf4;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  res_t        q[$];
  res_t        q4[$];

  always #5 clk1 = ~clk1;

  inv_pulse_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk1       (clk1),
    .rstn1      (rstn1),
    .sig_in     (sig_in),
    .meas_en    (meas_en),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .period_cnt (period_cnt),
    .ovf        (ovf)
  );

  inv_pulse_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk1       (clk1),
    .rstn1      (rstn1),
    .sig_in     (sig_in),
    .meas_en    (meas_en4),
    .meas_ready (1'b1),
    .meas_valid (meas_valid4),
    .high_cnt   (high_cnt4),
    .low_cnt    (low_cnt4),
    .period_cnt (period_cnt4),
    .ovf        (ovf4)
  );

  // Result monitor: capture each result once, on the first cycle of valid.
  initial begin
    logic vp, vp4;
    res_t r;
    vp  = 1'b0;
    vp4 = 1'b0;
    forever begin
      @(negedge clk1);
      if (meas_valid && !vp) begin
        r.h = high_cnt; r.l = low_cnt; r.p = period_cnt; r.o = ovf;
        q.push_back(r);
      end
      if (meas_valid4 && !vp4) begin
        r.h = high_cnt4; r.l = low_cnt4; r.p = period_cnt4; r.o = ovf4;
        q4.push_back(r);
      end
      vp  = meas_valid;
      vp4 = meas_valid4;
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk1);
  endtask

  task automatic square(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      cyc(h);
      sig_in = 1'b0;
      cyc(l);
    end
  endtask

  task automatic prep(input logic en, input logic en4);
    meas_en  = 1'b0;
    meas_en4 = 1'b0;
    sig_in   = 1'b0;
    cyc(6);
    q.delete();
    q4.delete();
    meas_en  = en;
    meas_en4 = en4;
    cyc(2);
  endtask

  task automatic check_res(input string tag, input int i, input logic wide,
                           input int unsigned h, input int unsigned l,
                           input int unsigned p, input int unsigned o);
    res_t r;
    int unsigned sz;
    sz = wide ? q.size() : q4.size();
    check({tag, "_present"}, (sz > i) ? 1 : 0, 1);
    if (sz > i) begin
      r = wide ? q[i] : q4[i];
      check({tag, "_high"}, r.h, h);
      check({tag, "_low"}, r.l, l);
      check({tag, "_period"}, r.p, p);
      check({tag, "_ovf"}, r.o, o);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, meas_valid, 0);
    check({tag, "_high"}, high_cnt, 0);
    check({tag, "_low"}, low_cnt, 0);
    check({tag, "_period"}, period_cnt, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn1      = 1'b0;
    sig_in     = 1'b0;
    meas_en    = 1'b0;
    meas_en4   = 1'b0;
    meas_ready = 1'b1;
    cyc(3);
    check_zero("reset");
    check("reset_valid4", meas_valid4, 0);
    rstn1 = 1'b1;

    // 10 high / 10 low: the 5th period opens a measurement that never closes.
    prep(1'b1, 1'b0);
    square(10, 10, 5);
    cyc(10);
    check("sq10_count", q.size(), 2);
    check_res("sq10_r0", 0, 1'b1, 10, 10, 20, 0);
    check_res("sq10_r1", 1, 1'b1, 10, 10, 20, 0);

    prep(1'b1, 1'b0);
    square(3, 7, 5);
    cyc(10);
    check_res("sq3_7", 0, 1'b1, 3, 7, 10, 0);

    prep(1'b1, 1'b0);
    square(1, 1, 5);
    cyc(10);
    check("sq1_count", q.size(), 2);
    check_res("sq1_1", 1, 1'b1, 1, 1, 2, 0);

    // Back-pressure: result must hold while edges keep arriving.
    prep(1'b1, 1'b0);
    meas_ready = 1'b0;
    square(10, 10, 2);
    fork
      square(10, 10, 8);
    join_none
    for (int i = 0; i < 3; i++) begin
      cyc(20);
      check("hold_valid", meas_valid, 1);
      check("hold_high", high_cnt, 10);
      check("hold_low", low_cnt, 10);
    end
    meas_ready = 1'b1;
    cyc(1);
    check("release_valid", meas_valid, 0);
    q.delete();
    wait fork;
    cyc(10);
    check_res("after_hold", 0, 1'b1, 10, 10, 20, 0);

    // Saturation on the 4-bit instance, then a clean run clears ovf.
    prep(1'b0, 1'b1);
    square(20, 5, 5);
    cyc(10);
    check_res("sat_r0", 0, 1'b0, 15, 5, 20, 1);
    check_res("sat_r1", 1, 1'b0, 15, 5, 20, 1);
    prep(1'b0, 1'b1);
    square(4, 4, 5);
    cyc(10);
    check_res("clean4", 0, 1'b0, 4, 4, 8, 0);

    // Abort while measuring the low phase.
    prep(1'b1, 1'b0);
    sig_in = 1'b1;
    cyc(10);
    sig_in = 1'b0;
    cyc(6);
    check("abort_pre_high", high_cnt, 10);
    meas_en = 1'b0;
    cyc(1);
    check_zero("abort");
    meas_en = 1'b1;
    cyc(2);
    square(10, 10, 5);
    cyc(10);
    check_res("reenable", 0, 1'b1, 10, 10, 20, 0);

    // Reset while a result is pending.
    prep(1'b1, 1'b0);
    meas_ready = 1'b0;
    square(10, 10, 2);
    check("pre_rst_valid", meas_valid, 1);
    rstn1 = 1'b0;
    cyc(1);
    check_zero("midrst");
    rstn1      = 1'b1;
    meas_ready = 1'b1;
    q.delete();
    square(10, 10, 5);
    cyc(10);
    check("post_rst_count", q.size(), 2);
    check_res("post_rst", 0, 1'b1, 10, 10, 20, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
